amp_i2c_seq: RTL and testbench

Parametrised I2C configuration sequencer for the amplifier interface, successor to the fixed single-register amp I2C master. On a trigger it fetches a byte-coded program from an external synchronous ROM and executes single-byte writes, auto-incrementing block writes and timed waits to a configurable 7-bit device address. It checks every ACK, retries NACKed transactions, and reports busy/done/error to the control logic. It sits between the top-level control FSM and the amplifier SDA/SCL pads.

---
 rtl/amp_i2c_seq_if.sv | 26 ++
 rtl/amp_i2c_seq.sv | 214 +++++++++++++++++++++
 tb/tb_amp_i2c_seq.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/amp_i2c_seq_if.sv
// Pad-side I2C lines and program-ROM port of the amplifier configuration sequencer.
interface amp_i2c_seq_if #(
   parameter int unsigned ROM_AW = 4
);
   logic              sdai;
   logic              sdao;
   logic              scl;
   logic [ROM_AW-1:0] rom_addr;
   logic [7:0]        rom_data;

   modport master (
      input  sdai,
      input  rom_data,
      output sdao,
      output scl,
      output rom_addr
   );

   modport slave (
      output sdai,
      output rom_data,
      input  sdao,
      input  scl,
      input  rom_addr
   );
endinterface

// File: rtl/amp_i2c_seq.sv
// ROM-programmed I2C write sequencer for the amplifier: single writes, block writes and
// timed waits, with ACK checking and bounded retries.
//
// state  | meaning
// IDLE   | bus released, waiting for send_cfg
// FETCH  | rom_addr driven, rom_data registered on the second cycle
// DECODE | classify opcode, arm the transaction or wait counter
// START  | two-tick START condition
// BYTE   | eight data bits, four ticks each
// ACK    | ninth bit, SDA released, slave sampled on phase 2
// STOP   | three-tick STOP condition, then retry/skip/advance
// WAIT   | bus idle for (w+1)*256 ticks
// DONE   | program finished, waiting for send_cfg
module amp_i2c_seq #(
   parameter int unsigned CLK_DIV  = 5,
   parameter logic [6:0]  DEV_ADDR = 7'h20,
   parameter int unsigned ROM_AW   = 4,
   parameter int unsigned RETRIES  = 2
) (
   input  logic          clk_in,
   input  logic          reset,
   input  logic          send_cfg,
   amp_i2c_seq_if.master bus,
   output logic          busy,
   output logic          done,
   output logic          nack_err
);

   localparam int unsigned TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned PW = ROM_AW + 1;
   localparam logic [PW-1:0] PC_END = {1'b1, {ROM_AW{1'b0}}};
   localparam logic [7:0] RETRY_MAX = 8'(RETRIES);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_START, S_BYTE, S_ACK, S_STOP, S_WAIT, S_DONE
   } state_t;

   state_t          state, state_nxt;
   logic [TW-1:0]   tick_cnt;
   logic            tick;
   logic [PW-1:0]   pc, op_pc, skip_pc;
   logic [15:0]     skip_sum;
   logic            fetch_rdy;
   logic [7:0]      cmd;
   logic [7:0]      sh;
   logic [2:0]      bit_cnt;
   logic [1:0]      ph;
   logic [5:0]      bytes_left;
   logic            first_byte;
   logic            ack_bad;
   logic [7:0]      retry_cnt;
   logic [12:0]     wait_cnt;
   logic            scl_d, sdao_d;

   function automatic logic [PW-1:0] pc_inc(input logic [PW-1:0] p);
      return p[ROM_AW] ? p : p + PW'(1);
   endfunction

   always_ff @(posedge clk_in) begin
      if (reset || tick) tick_cnt <= TW'(CLK_DIV - 1);
      else               tick_cnt <= tick_cnt - TW'(1);
   end
   assign tick = (tick_cnt == '0);

   // A NACK-exhausted transaction is skipped as a whole; clamp at the end of ROM.
   always_comb begin
      skip_sum = 16'(op_pc) + (cmd[7] ? 16'(cmd[4:0]) + 16'd3 : 16'd2);
      skip_pc  = (skip_sum >= 16'(PC_END)) ? PC_END : skip_sum[PW-1:0];
   end

   always_ff @(posedge clk_in) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (send_cfg) state_nxt = S_FETCH;
         S_FETCH: begin
            if (pc[ROM_AW])     state_nxt = S_DONE;
            else if (fetch_rdy) state_nxt = S_DECODE;
         end
         S_DECODE: begin
            casez (cmd)
               8'b0???_????, 8'b110?_????: state_nxt = S_START;
               8'b1110_????:               state_nxt = S_WAIT;
               default:                    state_nxt = S_DONE;
            endcase
         end
         S_START: if (tick && ph == 2'd1) state_nxt = S_BYTE;
         S_BYTE:  if (tick && ph == 2'd3 && bit_cnt == 3'd0) state_nxt = S_ACK;
         S_ACK: begin
            if (tick && ph == 2'd3)
               state_nxt = (ack_bad || bytes_left == 6'd0) ? S_STOP : S_BYTE;
         end
         S_STOP: if (tick && ph == 2'd2) state_nxt = S_FETCH;
         S_WAIT: if (tick && wait_cnt == 13'd1) state_nxt = S_FETCH;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      scl_d  = 1'b1;
      sdao_d = 1'b1;
      busy   = 1'b1;
      done   = 1'b0;
      case (state)
         S_IDLE: busy = 1'b0;
         S_DONE: begin
            busy = 1'b0;
            done = 1'b1;
         end
         S_START: sdao_d = (ph == 2'd0);
         S_BYTE: begin
            scl_d  = (ph == 2'd1) || (ph == 2'd2);
            sdao_d = sh[bit_cnt];
         end
         S_ACK: scl_d = (ph == 2'd1) || (ph == 2'd2);
         S_STOP: begin
            scl_d  = (ph != 2'd0);
            sdao_d = (ph == 2'd2);
         end
         default: ;
      endcase
   end

   assign bus.scl      = scl_d;
   assign bus.sdao     = sdao_d;
   assign bus.rom_addr = pc[ROM_AW-1:0];

   always_ff @(posedge clk_in) begin
      if (reset) begin
         pc         <= '0;
         op_pc      <= '0;
         fetch_rdy  <= 1'b0;
         cmd        <= 8'd0;
         sh         <= 8'd0;
         bit_cnt    <= 3'd0;
         ph         <= 2'd0;
         bytes_left <= 6'd0;
         first_byte <= 1'b0;
         ack_bad    <= 1'b0;
         retry_cnt  <= 8'd0;
         wait_cnt   <= 13'd0;
         nack_err   <= 1'b0;
      end else begin
         if (state_nxt != state) ph <= 2'd0;
         else if (tick)          ph <= ph + 2'd1;

         case (state)
            S_IDLE, S_DONE: begin
               if (send_cfg) begin
                  pc        <= '0;
                  nack_err  <= 1'b0;
                  retry_cnt <= 8'd0;
               end
            end
            S_FETCH: begin
               if (!pc[ROM_AW]) begin
                  if (fetch_rdy) begin
                     cmd       <= bus.rom_data;
                     fetch_rdy <= 1'b0;
                  end else begin
                     fetch_rdy <= 1'b1;
                  end
               end
            end
            S_DECODE: begin
               op_pc      <= pc;
               pc         <= pc_inc(pc);
               sh         <= {DEV_ADDR, 1'b0};
               bit_cnt    <= 3'd7;
               first_byte <= 1'b1;
               ack_bad    <= 1'b0;
               bytes_left <= cmd[7] ? 6'(cmd[4:0]) + 6'd2 : 6'd2;
               wait_cnt   <= {({1'b0, cmd[3:0]} + 5'd1), 8'h00};
            end
            S_BYTE: if (tick && ph == 2'd3) bit_cnt <= bit_cnt - 3'd1;
            S_ACK: begin
               if (tick && ph == 2'd2) ack_bad <= bus.sdai;
               // Next byte is preloaded here; rom_addr has been stable for a whole byte.
               if (tick && ph == 2'd3 && !ack_bad && bytes_left != 6'd0) begin
                  bytes_left <= bytes_left - 6'd1;
                  first_byte <= 1'b0;
                  if (first_byte && !cmd[7]) begin
                     sh <= {1'b0, cmd[6:0]};
                  end else begin
                     sh <= bus.rom_data;
                     pc <= pc_inc(pc);
                  end
               end
            end
            S_STOP: begin
               if (tick && ph == 2'd2) begin
                  if (!ack_bad) begin
                     retry_cnt <= 8'd0;
                  end else if (retry_cnt < RETRY_MAX) begin
                     retry_cnt <= retry_cnt + 8'd1;
                     pc        <= op_pc;
                  end else begin
                     retry_cnt <= 8'd0;
                     nack_err  <= 1'b1;
                     pc        <= skip_pc;
                  end
               end
            end
            S_WAIT: if (tick) wait_cnt <= wait_cnt - 13'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_amp_i2c_seq.sv
// Bench for amp_i2c_seq: bus monitor and slave, ROM model, and a program-level reference
// model that derives the expected I2C frames straight from the opcode rules.
module tb_amp_i2c_seq;
   localparam int CLK_DIV = 5;
   localparam int ROM_AW  = 4;
   localparam int RETRIES = 2;
   localparam logic [7:0] ADDR_BYTE = 8'h40;

   typedef logic [7:0] bq_t[$];

   logic clk_in = 1'b0;
   logic reset = 1'b1;
   logic send_cfg = 1'b0;
   logic busy, done, nack_err;

   amp_i2c_seq_if #(.ROM_AW(ROM_AW)) bus ();

   amp_i2c_seq #(
      .CLK_DIV(CLK_DIV), .DEV_ADDR(7'h20), .ROM_AW(ROM_AW), .RETRIES(RETRIES)
   ) dut (
      .clk_in(clk_in), .reset(reset), .send_cfg(send_cfg), .bus(bus),
      .busy(busy), .done(done), .nack_err(nack_err)
   );

   always #5 clk_in = ~clk_in;

   logic [7:0] rom [16];
   always @(posedge clk_in) bus.rom_data <= rom[bus.rom_addr];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // bus monitor and slave
   bit nack_all = 1'b0;
   int cyc = 0;
   logic p_scl = 1'b1, p_sda = 1'b1, s_scl, s_sda;
   bit in_frame = 1'b0, have_stop = 1'b0;
   int fbits, fbytes, bib, st_cyc, stop_cyc;
   logic [7:0] cur;
   int m_bytes[$], m_len[$], m_dur[$], m_start[$], m_gap[$];

   always @(negedge clk_in) begin
      cyc++;
      s_scl = bus.scl;
      s_sda = bus.sdao;
      if (p_scl && s_scl && p_sda && !s_sda) begin
         in_frame = 1'b1;
         fbits = 0; fbytes = 0; bib = 0; cur = 8'd0;
         st_cyc = cyc;
         m_start.push_back(cyc);
         if (have_stop) m_gap.push_back(cyc - stop_cyc);
      end else if (p_scl && s_scl && !p_sda && s_sda && in_frame) begin
         in_frame = 1'b0;
         m_len.push_back(fbytes);
         m_dur.push_back(cyc - st_cyc);
         stop_cyc = cyc;
         have_stop = 1'b1;
      end else if (!p_scl && s_scl && in_frame) begin
         fbits++;
         if (bib < 8) cur = {cur[6:0], s_sda};
         bib++;
         if (bib == 9) begin
            m_bytes.push_back(int'(cur));
            fbytes++;
            bib = 0;
         end
      end
      p_scl = s_scl;
      p_sda = s_sda;
      bus.sdai = (nack_all && in_frame && fbits <= 9);
   end

   // reference model: walk the program by opcode rules
   int  e_bytes[$], e_len[$];
   bit  e_err;

   task automatic build_model(input bit nack);
      int pc, n, len;
      logic [7:0] op;
      e_bytes.delete();
      e_len.delete();
      e_err = 1'b0;
      pc = 0;
      while (pc < 16) begin
         op = rom[pc];
         if (op[7] == 1'b0) begin
            n = 0; len = 2;
         end else if (op[7:5] == 3'b110) begin
            n = int'(op[4:0]) + 1; len = n + 2;
         end else if (op[7:4] == 4'b1110) begin
            pc++;
            continue;
         end else begin
            break;
         end
         if (nack) begin
            for (int a = 0; a <= RETRIES; a++) begin
               e_bytes.push_back(int'(ADDR_BYTE));
               e_len.push_back(1);
            end
            e_err = 1'b1;
         end else begin
            e_bytes.push_back(int'(ADDR_BYTE));
            if (n == 0) begin
               e_bytes.push_back(int'(op[6:0]));
               e_bytes.push_back(int'(rom[pc + 1]));
               e_len.push_back(3);
            end else begin
               for (int k = 1; k <= n + 1; k++) e_bytes.push_back(int'(rom[pc + k]));
               e_len.push_back(n + 2);
            end
         end
         pc += len;
      end
   endtask

   task automatic load_rom(input bq_t v);
      for (int i = 0; i < 16; i++) rom[i] = 8'hFF;
      for (int i = 0; i < v.size() && i < 16; i++) rom[i] = v[i];
   endtask

   task automatic clear_mon();
      m_bytes.delete(); m_len.delete(); m_dur.delete(); m_start.delete(); m_gap.delete();
      have_stop = 1'b0;
   endtask

   int start_cyc;

   task automatic start_prog();
      @(posedge clk_in); #1 send_cfg = 1'b1;
      @(posedge clk_in); #1 send_cfg = 1'b0;
      check_val("busy_rise", busy, 1);
      start_cyc = cyc;
   endtask

   task automatic wait_done(input int limit);
      int n = 0;
      while (!done && n < limit) begin
         @(posedge clk_in); #1;
         n++;
      end
      check_val("done_seen", done, 1);
   endtask

   task automatic compare_run();
      check_val("frame_count", m_len.size(), e_len.size());
      check_val("byte_count", m_bytes.size(), e_bytes.size());
      for (int i = 0; i < e_len.size() && i < m_len.size(); i++) begin
         check_val($sformatf("frame%0d_len", i), m_len[i], e_len[i]);
         check_val($sformatf("frame%0d_ticks", i), m_dur[i], (36 * e_len[i] + 3) * CLK_DIV);
      end
      for (int j = 0; j < e_bytes.size() && j < m_bytes.size(); j++)
         check_val($sformatf("byte%0d", j), m_bytes[j], e_bytes[j]);
      foreach (m_gap[g]) check_val("idle_gap", 32'(m_gap[g] >= CLK_DIV), 1);
      check_val("nack_err", nack_err, e_err);
      check_val("busy_at_done", busy, 0);
   endtask

   task automatic run_prog(input bit nack);
      nack_all = nack;
      build_model(nack);
      clear_mon();
      start_prog();
      wait_done(40000);
      repeat (2) @(posedge clk_in);
      #1 compare_run();
   endtask

   task automatic gen_prog();
      int pos, n, kind;
      bit fin, waited;
      for (int i = 0; i < 16; i++) rom[i] = 8'hFF;
      pos = 0; fin = 1'b0; waited = 1'b0;
      while (pos < 16 && !fin) begin
         kind = int'($urandom_range(9));
         if (kind < 4 && pos + 2 <= 16) begin
            rom[pos]     = {1'b0, 7'($urandom_range(127))};
            rom[pos + 1] = 8'($urandom);
            pos += 2;
         end else if (kind < 7 && pos + 3 <= 16) begin
            n = int'($urandom_range(2));
            if (pos + 3 + n > 16) n = 16 - pos - 3;
            rom[pos] = {3'b110, 5'(n)};
            for (int k = 1; k <= n + 2; k++) rom[pos + k] = 8'($urandom);
            pos += 3 + n;
         end else if (kind == 7 && !waited) begin
            rom[pos] = 8'hE0;
            waited = 1'b1;
            pos++;
         end else begin
            case ($urandom_range(2))
               0:       rom[pos] = 8'hFF;
               1:       rom[pos] = {2'b10, 6'($urandom)};
               default: rom[pos] = {4'hF, 4'($urandom)};
            endcase
            fin = 1'b1;
         end
      end
   endtask

   initial begin
      bq_t p;
      int d, n;
      bus.sdai = 1'b0;
      for (int i = 0; i < 16; i++) rom[i] = 8'hFF;

      repeat (3) @(posedge clk_in);
      #1;
      check_val("rst_sdao", bus.sdao, 1);
      check_val("rst_scl", bus.scl, 1);
      check_val("rst_rom_addr", bus.rom_addr, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_nack_err", nack_err, 0);
      reset = 1'b0;

      p = '{8'h00, 8'h18, 8'hFF};
      load_rom(p);
      run_prog(1'b0);

      p = '{8'hC1, 8'h10, 8'hAA, 8'h55, 8'hFF};
      load_rom(p);
      run_prog(1'b0);

      p = '{8'hE0, 8'h35, 8'h08, 8'hFF};
      load_rom(p);
      run_prog(1'b0);
      d = (m_start.size() > 0) ? m_start[0] - start_cyc : 0;
      check_val("wait_idle_len", 32'((d >= 255 * CLK_DIV) && (d <= 260 * CLK_DIV)), 1);

      p = '{8'h00, 8'h18, 8'h01, 8'h22, 8'hFF};
      load_rom(p);
      run_prog(1'b1);

      // send_cfg held high through the first transaction must not restart the program
      load_rom(p);
      nack_all = 1'b0;
      build_model(1'b0);
      clear_mon();
      @(posedge clk_in); #1 send_cfg = 1'b1;
      @(posedge clk_in); #1 check_val("hold_busy_rise", busy, 1);
      n = 0;
      while (m_len.size() < 1 && n < 5000) begin
         @(posedge clk_in); #1;
         n++;
      end
      check_val("hold_first_frame", 32'(m_len.size() >= 1), 1);
      send_cfg = 1'b0;
      wait_done(40000);
      repeat (2) @(posedge clk_in);
      #1 compare_run();

      // reset in the middle of a byte
      p = '{8'h00, 8'h18, 8'hFF};
      load_rom(p);
      nack_all = 1'b0;
      clear_mon();
      start_prog();
      n = 0;
      while (!(in_frame && fbits >= 4) && n < 5000) begin
         @(posedge clk_in); #1;
         n++;
      end
      check_val("midbyte_reached", 32'(in_frame && fbits >= 4), 1);
      reset = 1'b1;
      @(posedge clk_in); #1;
      check_val("mid_rst_scl", bus.scl, 1);
      check_val("mid_rst_sdao", bus.sdao, 1);
      check_val("mid_rst_busy", busy, 0);
      check_val("mid_rst_rom_addr", bus.rom_addr, 0);
      check_val("mid_rst_done", done, 0);
      reset = 1'b0;
      repeat (50) @(posedge clk_in);
      #1 check_val("idle_after_rst", busy, 0);

      // program without an end opcode runs to the last ROM address
      for (int i = 0; i < 8; i++) begin
         rom[2 * i]     = 8'(i + 3);
         rom[2 * i + 1] = 8'($urandom);
      end
      run_prog(1'b0);

      for (int r = 0; r < 6; r++) begin
         gen_prog();
         run_prog($urandom_range(3) == 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
